// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: state codes, opcodes, mux selects.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package control_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'd3;
    localparam logic [6:0] OP_SW    = 7'd35;
    localparam logic [6:0] OP_RTYPE = 7'd51;
    localparam logic [6:0] OP_ADDI  = 7'd19;
    localparam logic [6:0] OP_BEQ   = 7'd99;
    localparam logic [6:0] OP_JAL   = 7'd111;

    // result_src
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    // alu_src_a
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    // alu_src_b
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    // alu_op
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // imm_src
    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/control_multicycle_fsm_if.sv
// Bundle of the control unit's datapath-facing signals (opcode/flags in, control word out).
// Latency: n/a (wiring only).
// Backpressure: n/a; mem_ready is the only stall input and it travels master->slave.
// master: datapath side, drives opcode/zero/mem_ready. slave: control FSM, drives the control word.
interface control_multicycle_fsm_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal_instr, state
    );

    modport slave (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal_instr, state
    );
endinterface

// File: rtl/control_imm_decoder.sv
// Immediate-format select decoded straight from the opcode field.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: opcode (in, 7b) -> imm_src (out, 2b).
module control_imm_decoder
    import control_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;    // lw, addi and anything unrecognised
        case (opcode)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/control_multicycle_fsm_core.sv
// Moore control FSM for the multicycle RV32 subset (lw, sw, R-type, addi, beq, jal).
// Latency: control word follows state combinationally; one state step per clk.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready.
// Ports: clk, reset (async, active-high), bus (slave modport: opcode/zero/mem_ready in, control word out).
module control_multicycle_fsm_core
    import control_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    control_multicycle_fsm_if.slave    bus
);

    state_t     state_q, state_d;

    logic       pc_write_c, adr_src_c, mem_write_c, ir_write_c;
    logic       reg_write_c, illegal_c;
    logic [1:0] result_src_c, alu_src_a_c, alu_src_b_c, alu_op_c;
    logic [1:0] imm_src_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        illegal_c    = 1'b0;
        result_src_c = RES_ALUOUT;
        alu_src_a_c  = SRCA_PC;
        alu_src_b_c  = SRCB_RS2;
        alu_op_c     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                // PC+4 is routed straight from the ALU; both enables fire only on
                // the cycle the instruction word actually arrives.
                alu_src_b_c  = SRCB_FOUR;
                result_src_c = RES_ALURESULT;
                if (bus.mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively compute OldPC+imm into ALUOut for beq/jal.
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_IMM;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECR;
                    OP_ADDI:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                state_d     = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src_c = 1'b1;
                if (bus.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src_c = RES_DATA;
                reg_write_c  = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEMWRITE: begin
                // Strobe stays up for the whole wait, including the ready cycle.
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_IMM;
                alu_op_c    = ALUOP_FUNCT;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_d     = S_FETCH;
            end
            S_BEQ: begin
                // Target already sits in ALUOut; the subtract only feeds zero.
                alu_src_a_c = SRCA_RS1;
                alu_src_b_c = SRCB_RS2;
                alu_op_c    = ALUOP_SUB;
                pc_write_c  = bus.zero;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                // Redirect to the target in ALUOut while computing OldPC+4 for rd.
                alu_src_a_c = SRCA_OLDPC;
                alu_src_b_c = SRCB_FOUR;
                pc_write_c  = 1'b1;
                state_d     = S_ALUWB;
            end
            default: state_d = S_FETCH;
        endcase
    end

    control_imm_decoder u_imm_dec (
        .opcode  (bus.opcode),
        .imm_src (imm_src_c)
    );

    // Reset is async, so state is already FETCH while reset is high; the gate
    // stops FETCH's mem_ready-driven enables from leaking out during reset.
    assign bus.pc_write      = pc_write_c  & ~reset;
    assign bus.ir_write      = ir_write_c  & ~reset;
    assign bus.mem_write     = mem_write_c & ~reset;
    assign bus.reg_write     = reg_write_c & ~reset;
    assign bus.illegal_instr = illegal_c   & ~reset;
    assign bus.adr_src       = adr_src_c;
    assign bus.result_src    = result_src_c;
    assign bus.alu_src_a     = alu_src_a_c;
    assign bus.alu_src_b     = alu_src_b_c;
    assign bus.alu_op        = alu_op_c;
    assign bus.imm_src       = imm_src_c;
    assign bus.state         = state_q;

endmodule

// File: rtl/control_multicycle_fsm.sv
// Top of the multicycle control unit: flat pins wrapped around the interface-based FSM core.
// Latency: outputs are a Moore function of state (plus mem_ready/zero/opcode where noted).
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready.
// Ports: clk, reset (async, active-high); opcode/zero/mem_ready in; full control word, illegal_instr, state out.
module control_multicycle_fsm
    import control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal_instr,
    output logic [3:0] state
);

    control_multicycle_fsm_if ctrl_bus ();

    assign ctrl_bus.opcode    = opcode;
    assign ctrl_bus.zero      = zero;
    assign ctrl_bus.mem_ready = mem_ready;

    control_multicycle_fsm_core u_core (
        .clk   (clk),
        .reset (reset),
        .bus   (ctrl_bus.slave)
    );

    assign pc_write      = ctrl_bus.pc_write;
    assign adr_src       = ctrl_bus.adr_src;
    assign mem_write     = ctrl_bus.mem_write;
    assign ir_write      = ctrl_bus.ir_write;
    assign result_src    = ctrl_bus.result_src;
    assign alu_src_a     = ctrl_bus.alu_src_a;
    assign alu_src_b     = ctrl_bus.alu_src_b;
    assign alu_op        = ctrl_bus.alu_op;
    assign imm_src       = ctrl_bus.imm_src;
    assign reg_write     = ctrl_bus.reg_write;
    assign illegal_instr = ctrl_bus.illegal_instr;
    assign state         = ctrl_bus.state;

endmodule

// File: tb/tb_control_multicycle_fsm.sv
// Bench for control_multicycle_fsm: instruction-level route model plus per-state control table.
// Latency: n/a.
// Backpressure: mem_ready stalls driven from directed per-instruction settings.
module tb_control_multicycle_fsm;
    import control_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    control_multicycle_fsm_if bus ();

    control_multicycle_fsm dut (
        .clk           (clk),
        .reset         (rst),
        .opcode        (bus.opcode),
        .zero          (bus.zero),
        .mem_ready     (bus.mem_ready),
        .pc_write      (bus.pc_write),
        .adr_src       (bus.adr_src),
        .mem_write     (bus.mem_write),
        .ir_write      (bus.ir_write),
        .result_src    (bus.result_src),
        .alu_src_a     (bus.alu_src_a),
        .alu_src_b     (bus.alu_src_b),
        .alu_op        (bus.alu_op),
        .imm_src       (bus.imm_src),
        .reg_write     (bus.reg_write),
        .illegal_instr (bus.illegal_instr),
        .state         (bus.state)
    );

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] imm_src;
        logic       reg_write;
        logic       illegal_instr;
        logic [3:0] state;
    } ow_t;

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b1;

    // ---------------- model: instruction routes ----------------
    state_t m_state = S_FETCH;
    state_t path[$];

    function automatic void load_route(input logic [6:0] op);
        path.delete();
        path.push_back(S_DECODE);
        case (op)
            7'd3:   begin path.push_back(S_MEMADR); path.push_back(S_MEMREAD); path.push_back(S_MEMWB); end
            7'd35:  begin path.push_back(S_MEMADR); path.push_back(S_MEMWRITE); end
            7'd51:  begin path.push_back(S_EXECR); path.push_back(S_ALUWB); end
            7'd19:  begin path.push_back(S_EXECI); path.push_back(S_ALUWB); end
            7'd99:  path.push_back(S_BEQ);
            7'd111: begin path.push_back(S_JAL); path.push_back(S_ALUWB); end
            default: ;
        endcase
    endfunction

    always @(posedge rst) begin
        m_state = S_FETCH;
        path.delete();
    end

    always @(posedge clk) begin
        if (rst) begin
            m_state = S_FETCH;
            path.delete();
        end else if ((m_state == S_FETCH || m_state == S_MEMREAD || m_state == S_MEMWRITE)
                     && !bus.mem_ready) begin
            // memory wait: stay put
        end else begin
            if (m_state == S_FETCH) load_route(bus.opcode);
            if (path.size() == 0) m_state = S_FETCH;
            else                  m_state = path.pop_front();
        end
    end

    // ---------------- model: per-state control word ----------------
    function automatic ow_t expect_ow(input state_t s, input logic [6:0] op, input logic z,
                                      input logic mr, input logic r);
        ow_t w;
        w = '0;
        w.state = s;
        w.imm_src = (op == 7'd35) ? 2'b01 : (op == 7'd99) ? 2'b10 : (op == 7'd111) ? 2'b11 : 2'b00;
        case (s)
            S_FETCH:    begin w.alu_src_b = 2'b10; w.result_src = 2'b10; w.ir_write = mr; w.pc_write = mr; end
            S_DECODE:   begin
                w.alu_src_a = 2'b01; w.alu_src_b = 2'b01;
                w.illegal_instr = !(op == 7'd3 || op == 7'd35 || op == 7'd51 ||
                                    op == 7'd19 || op == 7'd99 || op == 7'd111);
            end
            S_MEMADR:   begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
            S_MEMREAD:  w.adr_src = 1'b1;
            S_MEMWB:    begin w.result_src = 2'b01; w.reg_write = 1'b1; end
            S_MEMWRITE: begin w.adr_src = 1'b1; w.mem_write = 1'b1; end
            S_EXECR:    begin w.alu_src_a = 2'b10; w.alu_op = 2'b10; end
            S_EXECI:    begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; w.alu_op = 2'b10; end
            S_ALUWB:    w.reg_write = 1'b1;
            S_BEQ:      begin w.alu_src_a = 2'b10; w.alu_op = 2'b01; w.pc_write = z; end
            S_JAL:      begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_write = 1'b1; end
            default:    ;
        endcase
        if (r) begin
            w.pc_write = 1'b0; w.ir_write = 1'b0; w.mem_write = 1'b0;
            w.reg_write = 1'b0; w.illegal_instr = 1'b0;
        end
        return w;
    endfunction

    ow_t act_w, exp_w;

    always @(negedge clk) begin
        if (chk_on) begin
            act_w.pc_write      = bus.pc_write;
            act_w.adr_src       = bus.adr_src;
            act_w.mem_write     = bus.mem_write;
            act_w.ir_write      = bus.ir_write;
            act_w.result_src    = bus.result_src;
            act_w.alu_src_a     = bus.alu_src_a;
            act_w.alu_src_b     = bus.alu_src_b;
            act_w.alu_op        = bus.alu_op;
            act_w.imm_src       = bus.imm_src;
            act_w.reg_write     = bus.reg_write;
            act_w.illegal_instr = bus.illegal_instr;
            act_w.state         = bus.state;
            exp_w = expect_ow(m_state, bus.opcode, bus.zero, bus.mem_ready, rst);
            checks++;
            if (act_w !== exp_w) begin
                errors++;
                $display("FAIL ctrl_word t=%0t got=%h want=%h", $time, act_w, exp_w);
            end
        end
    end

    // ---------------- directed checks ----------------
    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    function automatic int strobes();
        return {27'd0, bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write, bus.illegal_instr};
    endfunction

    // Runs one instruction starting in FETCH; returns per-instruction tallies of DUT outputs.
    task automatic run_instr(input logic [6:0] op, input logic z, input int fetch_stall,
                             input int mem_stall, output int cycles, output int n_pc_exec,
                             output int n_reg, output int n_mw, output int n_ir, output int n_ill,
                             output int n_data_wb, output int n_imm_j);
        int  fs, ms;
        bit  done;
        fs = fetch_stall; ms = mem_stall; done = 1'b0;
        cycles = 0; n_pc_exec = 0; n_reg = 0; n_mw = 0; n_ir = 0; n_ill = 0;
        n_data_wb = 0; n_imm_j = 0;
        bus.opcode = op;
        bus.zero   = z;
        for (int k = 0; k < 64 && !done; k++) begin
            if (m_state == S_FETCH) begin
                bus.mem_ready = (fs == 0);
                if (fs > 0) fs--;
            end else if (m_state == S_MEMREAD || m_state == S_MEMWRITE) begin
                bus.mem_ready = (ms == 0);
                if (ms > 0) ms--;
            end else begin
                bus.mem_ready = 1'b1;
            end
            @(negedge clk);
            if (bus.pc_write && k > fetch_stall) n_pc_exec++;
            if (bus.reg_write) n_reg++;
            if (bus.mem_write) n_mw++;
            if (bus.ir_write) n_ir++;
            if (bus.illegal_instr) n_ill++;
            if (bus.reg_write && bus.result_src == 2'b01) n_data_wb++;
            if (bus.imm_src == 2'b11) n_imm_j++;
            @(posedge clk); #1;
            cycles++;
            if (m_state == S_FETCH && k > fetch_stall) done = 1'b1;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL timeout op=%0d cycles=%0d want=return_to_fetch", op, cycles);
        end
    endtask

    int c, npc, nrg, nmw, nir, nil, ndw, nij;

    initial begin
        bus.opcode = 7'd0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
        #3;
        chk("reset_state", bus.state, S_FETCH);
        chk("reset_strobes", strobes(), 0);
        bus.mem_ready = 1'b1;
        #1;
        chk("reset_strobes_mr1", strobes(), 0);
        bus.mem_ready = 1'b0;
        #8 rst = 1'b0;                    // t=12, away from edges
        @(posedge clk); #1;

        // lw, memory always ready
        run_instr(7'd3, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("lw_cycles", c, 5);
        chk("lw_reg_write", nrg, 1);
        chk("lw_data_wb", ndw, 1);
        chk("lw_ir_write", nir, 1);
        chk("lw_mem_write", nmw, 0);

        // sw with 3-cycle stall in MEMWRITE
        run_instr(7'd35, 1'b0, 0, 3, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("sw_cycles", c, 7);
        chk("sw_mem_write", nmw, 4);
        chk("sw_reg_write", nrg, 0);

        // beq taken / not taken
        run_instr(7'd99, 1'b1, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("beq_t_cycles", c, 3);
        chk("beq_t_pc_write", npc, 1);
        run_instr(7'd99, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("beq_nt_cycles", c, 3);
        chk("beq_nt_pc_write", npc, 0);

        // jal
        run_instr(7'd111, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("jal_cycles", c, 4);
        chk("jal_pc_write", npc, 1);
        chk("jal_reg_write", nrg, 1);
        chk("jal_imm_j", nij, 4);

        // R-type, and addi with a 2-cycle fetch stall
        run_instr(7'd51, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("r_cycles", c, 4);
        chk("r_reg_write", nrg, 1);
        run_instr(7'd19, 1'b0, 2, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("addi_stall_cycles", c, 6);
        chk("addi_stall_ir_write", nir, 1);

        // unsupported opcode
        run_instr(7'h7F, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("ill_cycles", c, 2);
        chk("ill_pulse", nil, 1);
        chk("ill_reg_write", nrg, 0);
        chk("ill_mem_write", nmw, 0);
        chk("ill_pc_exec", npc, 0);

        // reset asserted mid-wait in MEMREAD
        bus.opcode = 7'd3; bus.mem_ready = 1'b1;
        @(posedge clk); #1;               // DECODE
        @(posedge clk); #1;               // MEMADR
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;               // MEMREAD
        @(posedge clk); #1;               // still MEMREAD
        chk("pre_reset_state", bus.state, S_MEMREAD);
        #1 rst = 1'b1;
        #1;
        chk("mid_reset_state", bus.state, S_FETCH);
        chk("mid_reset_strobes", strobes(), 0);
        bus.mem_ready = 1'b1;
        #1;
        chk("mid_reset_strobes_mr1", strobes(), 0);
        @(posedge clk); #1;
        chk("held_reset_state", bus.state, S_FETCH);
        @(negedge clk); #1 rst = 1'b0;
        #1;
        chk("post_reset_ir_write", bus.ir_write, 1);
        chk("post_reset_pc_write", bus.pc_write, 1);
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;
        run_instr(7'd19, 1'b0, 0, 0, c, npc, nrg, nmw, nir, nil, ndw, nij);
        chk("post_reset_addi_cycles", c, 4);
        chk("post_reset_addi_reg_write", nrg, 1);

        @(negedge clk);
        chk_on = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
